fsrc_tx_prefill_fifo: RTL and testbench
=======================================

# fsrc_tx_prefill_fifo

Elastic prefill buffer directly upstream of the TX fractional sample-rate converter (FSRC) stream input. It accepts DMA/packer data on an AXI-Stream slave and holds output valid low until a programmable fill level is reached. It then releases the stream and emits a one-cycle `tx_data_start` pulse that starts the FSRC accumulator in the same cycle as the first delivered word. While running it detects and reports underflow.

## Interface
- `DATA_WIDTH`, 256, stream word width in bits.
- `ADDR_WIDTH`, 4, log2 of FIFO depth (DEPTH = 2**ADDR_WIDTH words).
- `CNT_WIDTH`, 16, underflow counter width.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  level; 1 arms the block, 0 flushes it and returns it to IDLE.
- `prefill_level`  in  ADDR_WIDTH+1  fill threshold for release; 0 is treated as 1; values above DEPTH are clamped to DEPTH.
- `s_axis_valid`  in  1  upstream valid.
- `s_axis_ready`  out  1  upstream ready.
- `s_axis_data`  in  DATA_WIDTH  upstream word.
- `m_axis_valid`  out  1  valid toward the FSRC.
- `m_axis_ready`  in  1  FSRC ready.
- `m_axis_data`  out  DATA_WIDTH  word toward the FSRC.
- `tx_data_start`  out  1  one-cycle pulse on release.
- `level`  out  ADDR_WIDTH+1  current occupancy in words, 0..DEPTH.
- `underflow`  out  1  sticky underflow flag.
- `underflow_clear`  in  1  clears `underflow` (and the counter, if compiled in).
- `underflow_count`  out  CNT_WIDTH  saturating count of underflow cycles; tied to 0 when the feature is compiled out.

## Operation
- States:
  - IDLE: FIFO empty, pointers zeroed, `s_axis_ready`=0, `m_axis_valid`=0.
  - FILL: accepts data; `m_axis_valid`=0.
  - RUN: normal FIFO streaming.
- Transitions:
  - IDLE→FILL when `enable`=1.
  - FILL→RUN when `level` ≥ effective `prefill_level`.
  - Any state→IDLE when `enable`=0. The next cycle shows flushed contents and `level`=0; in-flight words are discarded.
- `tx_data_start` is 1 exactly in the first RUN cycle. It coincides with the first `m_axis_valid`=1 and is never re-asserted until the block passes through IDLE again.
- `s_axis_ready` = (state≠IDLE) && (`level` < DEPTH). It is derived from registered `level` only, with no full-bypass: at full, a simultaneous pop does not open ready in the same cycle.
- Push = `s_axis_valid`&&`s_axis_ready`. Pop = `m_axis_valid`&&`m_axis_ready`. `level` += push − pop each cycle, and simultaneous push and pop leaves `level` unchanged.
- In RUN, `m_axis_valid` = (`level`≠0). Data is first-word-fall-through, in order, and `m_axis_data` is stable while valid&&!ready.
- Underflow event: state=RUN && `m_axis_ready`=1 && `level`=0.
  - Sets `underflow`.
  - RUN is held and the block does not re-prefill.
- `underflow_clear` takes priority over a same-cycle underflow event: the result is cleared.
- Pointers wrap modulo DEPTH. `level` reaching DEPTH is a legal full state.

## Timing
- Reset values:
  - `s_axis_ready`=0, `m_axis_valid`=0, `m_axis_data`=0, `tx_data_start`=0.
  - `level`=0, `underflow`=0, `underflow_count`=0, state=IDLE.
- Reset overrides `enable`. Reset mid-RUN flushes like IDLE.
- Write-to-read latency is 1 cycle: a word pushed at edge N into an empty RUN FIFO is valid on `m_axis` after edge N+1.
- FILL→RUN is evaluated on registered `level`, so release occurs the cycle after the threshold word is pushed.
- `underflow` and `underflow_count` update one cycle after the event.

## Configuration
- `FSRC_TX_UNDERFLOW_CNT_EN` defined:
  - `underflow_count` increments by 1 per underflow cycle.
  - It saturates at 2**CNT_WIDTH−1 and is cleared by `underflow_clear`.
- Not defined: there is no counter logic, `underflow_count` is constant 0, and the sticky `underflow` flag remains.

## Structure
- Package `fsrc_tx_pkg`:
  - state enum `fsrc_tx_prefill_state_t` (IDLE, FILL, RUN).
  - localparam helpers for DEPTH.
- Sub-module `fsrc_tx_fifo_mem`: simple dual-port RAM with registered read, DEPTH×DATA_WIDTH, one write port and one read port.
- Top-level owns pointers, level, FSM, output register/FWFT logic and underflow logic.

## Test plan
- Prefill release: DEPTH=16, `prefill_level`=8, `enable`=1, push 8 words 0x1..0x8 with `m_axis_ready`=1.
  - `m_axis_valid` stays 0 until the cycle after the 8th push.
  - `tx_data_start` pulses once, with `m_axis_data`=0x1 in that cycle.
  - Words then drain in order.
- Full boundary: `prefill_level`=16, `m_axis_ready`=0, push 20 words.
  - Exactly 16 are accepted, `level`=16 and `s_axis_ready`=0.
  - One pop at full gives `level`=15, and ready returns the next cycle.
- Underflow: in RUN, drain to empty, then hold `m_axis_ready`=1 for 3 cycles.
  - `underflow`=1 and `underflow_count`=3 (with the macro).
  - `underflow_clear` returns both to 0.
- Flush: in RUN with `level`=5, drop `enable` for 1 cycle and then raise it again.
  - `level`=0 and `m_axis_valid`=0.
  - The block re-enters FILL, and the next release emits a fresh `tx_data_start`.
- Clamp and wrap: `prefill_level`=0 → release after 1 word. `prefill_level`=31 → release at 16. Stream 100 words with random valid/ready → output sequence identical to input, with no loss across pointer wrap.
- Reset mid-operation: assert `reset` during RUN with `level`=9 → all outputs at reset values the next cycle, state IDLE.

Source files
------------

// File: rtl/fsrc_tx_pkg.sv
// Shared state type and sizing helpers for the FSRC TX prefill FIFO.
package fsrc_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fsrc_tx_prefill_state_t;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fsrc_tx_fifo_mem.sv
// Simple dual-port RAM, one write port and one registered read port (read-before-write).
module fsrc_tx_fifo_mem
    import fsrc_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; occupancy
    // tracking in the parent decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fsrc_tx_prefill_fifo.sv
// Prefill FIFO in front of the TX FSRC: holds the stream until a fill level, then releases it.
// Optional saturating underflow counter: define FSRC_TX_UNDERFLOW_CNT_EN.
module fsrc_tx_prefill_fifo
    import fsrc_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH:0]   prefill_level,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  tx_data_start,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  underflow,
    input  logic                  underflow_clear,
    output logic [CNT_WIDTH-1:0]  underflow_count
);

    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    fsrc_tx_prefill_state_t state;
    logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr, rd_ptr_next;
    logic [ADDR_WIDTH:0]    threshold;
    logic                   push, pop, uf_event, byp_sel;
    logic [DATA_WIDTH-1:0]  byp_data, ram_q;

    assign s_axis_ready = (state != IDLE) && (level < FULL);
    assign m_axis_valid = (state == RUN) && (level != '0);
    assign push         = s_axis_valid && s_axis_ready;
    assign pop          = m_axis_valid && m_axis_ready;
    assign rd_ptr_next  = rd_ptr + ADDR_WIDTH'(pop);
    assign uf_event     = (state == RUN) && m_axis_ready && (level == '0);

    // The RAM read returns stale data when the head word is written on the same edge.
    assign m_axis_data  = byp_sel ? byp_data : ram_q;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        threshold = prefill_level;
        if (prefill_level == '0)      threshold = (ADDR_WIDTH+1)'(1);
        else if (prefill_level > FULL) threshold = FULL;
    end

    fsrc_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (s_axis_data),
        .rd_addr (rd_ptr_next),
        .rd_data (ram_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            tx_data_start <= 1'b0;
            byp_sel       <= 1'b1;
            byp_data      <= '0;
        end else begin
            wr_ptr        <= wr_ptr + ADDR_WIDTH'(push);
            rd_ptr        <= rd_ptr_next;
            level         <= level + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
            byp_sel       <= push && (wr_ptr == rd_ptr_next);
            byp_data      <= s_axis_data;
            tx_data_start <= 1'b0;
            case (state)
                IDLE: state <= FILL;
                FILL: if (level >= threshold) begin
                    state         <= RUN;
                    tx_data_start <= 1'b1;
                end
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || underflow_clear) underflow <= 1'b0;
        else if (uf_event)            underflow <= 1'b1;
    end

`ifdef FSRC_TX_UNDERFLOW_CNT_EN
    logic [CNT_WIDTH-1:0] uf_cnt;

    always_ff @(posedge clk) begin
        if (reset || underflow_clear)    uf_cnt <= '0;
        else if (uf_event && uf_cnt != '1) uf_cnt <= uf_cnt + 1'b1;
    end

    assign underflow_count = uf_cnt;
`else
    assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_fsrc_tx_prefill_fifo.sv
// Self-checking bench for fsrc_tx_prefill_fifo: vector table, directed corner cases, random stream vs queue model.
module tb_fsrc_tx_prefill_fifo;

    localparam int DW = 256;
    localparam int AW = 4;
    localparam int CW = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW:0]   prefill_level = 5'd8;
    logic          s_axis_valid = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic          m_axis_ready = 1'b0;
    logic          underflow_clear = 1'b0;
    logic          s_axis_ready, m_axis_valid, tx_data_start, underflow;
    logic [DW-1:0] m_axis_data;
    logic [AW:0]   level;
    logic [CW-1:0] underflow_count;

    fsrc_tx_prefill_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .prefill_level   (prefill_level),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .m_axis_valid    (m_axis_valid),
        .m_axis_ready    (m_axis_ready),
        .m_axis_data     (m_axis_data),
        .tx_data_start   (tx_data_start),
        .level           (level),
        .underflow       (underflow),
        .underflow_clear (underflow_clear),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: occupancy is a queue, phase 0/1/2 = idle/fill/run.
    logic [DW-1:0] m_q[$];
    int            m_phase = 0;
    logic          m_start = 1'b0;
    logic          m_uf = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] got[$];
    logic          dut_push;

    function automatic int exp_count();
`ifdef FSRC_TX_UNDERFLOW_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        int sz, eff;
        bit mpush, mpop, ev;
        sz    = m_q.size();
        mpush = (m_phase != 0) && (sz < DEPTH) && s_axis_valid;
        mpop  = (m_phase == 2) && (sz != 0) && m_axis_ready;
        ev    = (m_phase == 2) && m_axis_ready && (sz == 0);
        eff   = (prefill_level == 0) ? 1 : ((int'(prefill_level) > DEPTH) ? DEPTH : int'(prefill_level));
        dut_push = s_axis_valid && s_axis_ready;
        if (m_axis_valid && m_axis_ready) got.push_back(m_axis_data);
        if (mpop)  void'(m_q.pop_front());
        if (mpush) m_q.push_back(s_axis_data);
        m_start = 1'b0;
        if (reset || !enable) begin
            m_q.delete();
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 && sz >= eff) begin
            m_phase = 2;
            m_start = 1'b1;
        end
        if (reset || underflow_clear) begin
            m_uf  = 1'b0;
            m_cnt = 0;
        end else if (ev) begin
            m_uf = 1'b1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
        check("ready", DW'(s_axis_ready), DW'((m_phase != 0) && (m_q.size() < DEPTH)));
        check("valid", DW'(m_axis_valid), DW'((m_phase == 2) && (m_q.size() != 0)));
        check("level", DW'(level), DW'(m_q.size()));
        check("start", DW'(tx_data_start), DW'(m_start));
        check("underflow", DW'(underflow), DW'(m_uf));
        check("uf_count", DW'(underflow_count), DW'(exp_count()));
        if ((m_phase == 2) && (m_q.size() != 0)) check("data", m_axis_data, m_q[0]);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; s_axis_valid = 1'b0; m_axis_ready = 1'b0; underflow_clear = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    typedef struct {
        logic          rst, en;
        logic [AW:0]   pl;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          ev, er, es;
        logic [AW:0]   el;
        logic [DW-1:0] ed;
    } vec_t;

    function automatic vec_t mk(logic rst, logic en, logic sv, logic [DW-1:0] sd,
                                logic ev, logic er, logic es, logic [AW:0] el, logic [DW-1:0] ed);
        vec_t v;
        v.rst = rst; v.en = en; v.pl = 5'd8; v.sv = sv; v.sd = sd; v.mr = 1'b1;
        v.ev = ev; v.er = er; v.es = es; v.el = el; v.ed = ed;
        return v;
    endfunction

    vec_t          tbl[13];
    logic [DW-1:0] words[100];
    int            accepted, starts, idx;

    initial begin
        // Prefill release at level 8, words 1..8, sink always ready.
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) tbl[2+i] = mk(0, 1, 1, DW'(i+1), 0, 1, 0, 5'(i+1), 0);
        tbl[10] = mk(0, 1, 0, 0, 1, 1, 1, 5'd8, DW'(1));
        tbl[11] = mk(0, 1, 0, 0, 1, 1, 0, 5'd7, DW'(2));
        tbl[12] = mk(0, 1, 0, 0, 1, 1, 0, 5'd6, DW'(3));

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; prefill_level = tbl[i].pl;
            s_axis_valid = tbl[i].sv; s_axis_data = tbl[i].sd; m_axis_ready = tbl[i].mr;
            tick();
            check($sformatf("tbl%0d_valid", i), DW'(m_axis_valid), DW'(tbl[i].ev));
            check($sformatf("tbl%0d_ready", i), DW'(s_axis_ready), DW'(tbl[i].er));
            check($sformatf("tbl%0d_start", i), DW'(tx_data_start), DW'(tbl[i].es));
            check($sformatf("tbl%0d_level", i), DW'(level), DW'(tbl[i].el));
            if (tbl[i].ev) check($sformatf("tbl%0d_data", i), m_axis_data, tbl[i].ed);
        end

        // Full boundary: 20 offered, 16 accepted, one pop reopens ready next cycle.
        do_reset();
        check("reset_data", m_axis_data, '0);
        prefill_level = 5'd16; enable = 1'b1; tick();
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            s_axis_valid = 1'b1; s_axis_data = DW'(32'h100 + i);
            tick();
            if (dut_push) accepted++;
        end
        check("full_accepted", DW'(accepted), DW'(16));
        check("full_level", DW'(level), DW'(16));
        check("full_ready", DW'(s_axis_ready), DW'(0));
        m_axis_ready = 1'b1; tick();
        if (dut_push) accepted++;
        check("full_pop_accepted", DW'(accepted), DW'(16));
        check("full_pop_level", DW'(level), DW'(15));
        check("full_pop_ready", DW'(s_axis_ready), DW'(1));

        // Underflow: drain, then 3 ready cycles on an empty RUN FIFO.
        s_axis_valid = 1'b0;
        for (int c = 0; c < 40 && level != 0; c++) tick();
        check("drain_level", DW'(level), DW'(0));
        for (int i = 0; i < 3; i++) tick();
        m_axis_ready = 1'b0; tick();
        check("uf_flag", DW'(underflow), DW'(1));
`ifdef FSRC_TX_UNDERFLOW_CNT_EN
        check("uf_cnt3", DW'(underflow_count), DW'(3));
`else
        check("uf_cnt_off", DW'(underflow_count), DW'(0));
`endif
        underflow_clear = 1'b1; m_axis_ready = 1'b1; tick();
        underflow_clear = 1'b0; m_axis_ready = 1'b0;
        check("uf_clr_flag", DW'(underflow), DW'(0));
        check("uf_clr_cnt", DW'(underflow_count), DW'(0));

        // Flush from RUN at level 5, then a fresh release.
        do_reset();
        prefill_level = 5'd4; enable = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            s_axis_valid = 1'b1; s_axis_data = DW'(32'h200 + i); tick();
        end
        check("flush_pre_level", DW'(level), DW'(5));
        check("flush_pre_valid", DW'(m_axis_valid), DW'(1));
        s_axis_valid = 1'b0; enable = 1'b0; tick();
        check("flush_level", DW'(level), DW'(0));
        check("flush_valid", DW'(m_axis_valid), DW'(0));
        enable = 1'b1; starts = 0;
        for (int i = 0; i < 12; i++) begin
            s_axis_valid = 1'b1; s_axis_data = DW'(32'h300 + i); tick();
            if (tx_data_start) starts++;
        end
        check("flush_restart", DW'(starts), DW'(1));

        // Clamp: 0 releases after one word, 31 releases at 16.
        do_reset();
        prefill_level = 5'd0; enable = 1'b1; tick();
        s_axis_valid = 1'b1; s_axis_data = DW'(32'hABC); tick();
        s_axis_valid = 1'b0; tick();
        check("clamp0_start", DW'(tx_data_start), DW'(1));
        check("clamp0_data", m_axis_data, DW'(32'hABC));
        do_reset();
        prefill_level = 5'd31; enable = 1'b1; tick();
        for (int i = 0; i < 16; i++) begin
            s_axis_valid = 1'b1; s_axis_data = DW'(32'h400 + i); tick();
        end
        s_axis_valid = 1'b0; tick();
        check("clamp31_start", DW'(tx_data_start), DW'(1));
        check("clamp31_level", DW'(level), DW'(16));

        // Random stream of 100 words across pointer wrap.
        do_reset();
        for (int i = 0; i < 100; i++) words[i] = rand_word();
        prefill_level = 5'($urandom_range(1, 16)); enable = 1'b1;
        got.delete(); idx = 0;
        for (int c = 0; c < 3000 && got.size() < 100; c++) begin
            s_axis_valid = (idx < 100) && ($urandom_range(0, 1) == 1);
            s_axis_data  = (idx < 100) ? words[idx] : '0;
            m_axis_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (dut_push) idx++;
        end
        check("rand_count", DW'(got.size()), DW'(100));
        for (int i = 0; i < got.size() && i < 100; i++) check($sformatf("rand_word%0d", i), got[i], words[i]);

        // Reset mid-RUN at level 9.
        do_reset();
        prefill_level = 5'd9; enable = 1'b1; m_axis_ready = 1'b0; tick();
        for (int i = 0; i < 9; i++) begin
            s_axis_valid = 1'b1; s_axis_data = DW'(32'h500 + i); tick();
        end
        s_axis_valid = 1'b0; tick();
        check("mid_run_level", DW'(level), DW'(9));
        check("mid_run_valid", DW'(m_axis_valid), DW'(1));
        reset = 1'b1; tick();
        check("rst_ready", DW'(s_axis_ready), DW'(0));
        check("rst_valid", DW'(m_axis_valid), DW'(0));
        check("rst_data", m_axis_data, '0);
        check("rst_start", DW'(tx_data_start), DW'(0));
        check("rst_level", DW'(level), DW'(0));
        check("rst_uf", DW'(underflow), DW'(0));
        check("rst_cnt", DW'(underflow_count), DW'(0));
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
